// File: rtl/alu_pkg.sv
// +-------------------------------------------------------------------+
// | alu_pkg: shared ALUop, opcode and FSM encodings for the EX stage  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'd0,
    ASEL_ZERO = 2'd1,
    ASEL_PC   = 2'd2
  } asel_e;

  // alt picks SUB over ADD and SRA over SRL; callers decide when it applies.
  function automatic logic [3:0] f3_to_aluop(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// +-------------------------------------------------------------------+
// | alu_op_decode: opcode/funct -> ALUop, operand selects, illegal    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_op_o,
  output asel_e      a_sel_o,
  output logic       b_imm_o,
  output logic       shift_o,
  output logic       branch_o,
  output logic       br_inv_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    a_sel_o   = ASEL_RS1;
    b_imm_o   = 1'b0;
    shift_o   = 1'b0;
    branch_o  = 1'b0;
    br_inv_o  = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        alu_op_o  = f3_to_aluop(funct3_i, funct7b5_i);
        shift_o   = (funct3_i[1:0] == 2'b01);
        illegal_o = funct7b5_i && (funct3_i != 3'b000) && (funct3_i != 3'b101);
      end
      OPC_OPIMM: begin
        b_imm_o   = 1'b1;
        alu_op_o  = f3_to_aluop(funct3_i, funct7b5_i && (funct3_i == 3'b101));
        shift_o   = (funct3_i[1:0] == 2'b01);
        illegal_o = funct7b5_i && (funct3_i == 3'b001);
      end
      OPC_LUI: begin
        a_sel_o = ASEL_ZERO;
        b_imm_o = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel_o = ASEL_PC;
        b_imm_o = 1'b1;
      end
      OPC_BRANCH: begin
        branch_o = 1'b1;
        // taken = zero ^ br_inv: equality tests zero directly, less-than tests !zero
        case (funct3_i[2:1])
          2'b00: begin
            alu_op_o = ALU_SUB;
            br_inv_o = funct3_i[0];
          end
          2'b10: begin
            alu_op_o = ALU_SLT;
            br_inv_o = ~funct3_i[0];
          end
          2'b11: begin
            alu_op_o = ALU_SLTU;
            br_inv_o = ~funct3_i[0];
          end
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
// +-------------------------------------------------------------------+
// | alu_exec_ctrl: EX-stage issue FSM driving an external comb. ALU   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic              branch_q, branch_d, inv_q, inv_d;
  logic              taken_q, taken_d, illegal_q, illegal_d;

  logic [3:0]        dec_op;
  asel_e             dec_a_sel;
  logic              dec_b_imm, dec_shift, dec_branch, dec_inv, dec_illegal;
  logic [XLEN-1:0]   b_src;

  alu_op_decode u_decode (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_op_o   (dec_op),
    .a_sel_o    (dec_a_sel),
    .b_imm_o    (dec_b_imm),
    .shift_o    (dec_shift),
    .branch_o   (dec_branch),
    .br_inv_o   (dec_inv),
    .illegal_o  (dec_illegal)
  );

  assign b_src = dec_b_imm ? imm : rs2_val;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    branch_d  = branch_q;
    inv_d     = inv_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d     = dec_op;
          branch_d = dec_branch;
          inv_d    = dec_inv;
          case (dec_a_sel)
            ASEL_ZERO: a_d = '0;
            ASEL_PC:   a_d = pc;
            default:   a_d = rs1_val;
          endcase
          // Shift amounts wrap modulo 2**SHAMT_W, so the ALU only ever sees the low bits.
          b_d = dec_shift ? {{(XLEN-SHAMT_W){1'b0}}, b_src[SHAMT_W-1:0]} : b_src;
          if (dec_illegal) begin
            result_d  = '0;
            taken_d   = 1'b0;
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            illegal_d = 1'b0;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        result_d = branch_q ? '0 : alu_out;
        taken_d  = branch_q & (alu_zero ^ inv_q);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      branch_q  <= 1'b0;
      inv_q     <= 1'b0;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      branch_q  <= branch_d;
      inv_q     <= inv_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign alu_op       = (state_q == ST_ISSUE) ? op_q : '0;
  assign alu_a        = (state_q == ST_ISSUE) ? a_q  : '0;
  assign alu_b        = (state_q == ST_ISSUE) ? b_q  : '0;
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign illegal      = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
// +-------------------------------------------------------------------+
// | tb_alu_exec_ctrl: scoreboard bench with behavioural ALU/ISA model |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rs1_val, rs2_val, imm, pc;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        branch_taken, illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        tk;
    logic        ill;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t scb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_taken(branch_taken), .illegal(illegal)
  );

  // External combinational ALU
  always_comb begin
    case (alu_op)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd3:    alu_out = alu_a ^ alu_b;
      4'd4:    alu_out = alu_a << alu_b[4:0];
      4'd5:    alu_out = alu_a >> alu_b[4:0];
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = {31'b0, alu_a < alu_b};
      4'd8:    alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd9:    alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_out = 32'h0;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: what each RV32I instruction means
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] im, input logic [31:0] pcv);
    exp_t e;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        isop;
    e = '0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      isop = (opc == 7'b0110011);
      b    = isop ? rs2 : im;
      sh   = b[4:0];
      e.a  = rs1;
      e.b  = b;
      if (isop && f7 && f3 != 3'd0 && f3 != 3'd5) e.ill = 1'b1;
      if (!isop && f3 == 3'd1 && f7) e.ill = 1'b1;
      case (f3)
        3'd0: if (isop && f7) begin e.res = rs1 - b; e.op = 4'd6; end
              else begin e.res = rs1 + b; e.op = 4'd2; end
        3'd1: begin e.res = rs1 << sh; e.op = 4'd4; e.b = {27'b0, sh}; end
        3'd2: begin e.res = {31'b0, $signed(rs1) < $signed(b)}; e.op = 4'd8; end
        3'd3: begin e.res = {31'b0, rs1 < b}; e.op = 4'd7; end
        3'd4: begin e.res = rs1 ^ b; e.op = 4'd3; end
        3'd5: begin
          e.b = {27'b0, sh};
          if (f7) begin e.res = $unsigned($signed(rs1) >>> sh); e.op = 4'd9; end
          else begin e.res = rs1 >> sh; e.op = 4'd5; end
        end
        3'd6: begin e.res = rs1 | b; e.op = 4'd1; end
        default: begin e.res = rs1 & b; e.op = 4'd0; end
      endcase
    end else if (opc == 7'b0110111) begin
      e.a = 32'h0; e.b = im; e.res = im; e.op = 4'd2;
    end else if (opc == 7'b0010111) begin
      e.a = pcv; e.b = im; e.res = pcv + im; e.op = 4'd2;
    end else if (opc == 7'b1100011) begin
      e.a = rs1; e.b = rs2;
      case (f3)
        3'd0: begin e.tk = (rs1 == rs2); e.op = 4'd6; end
        3'd1: begin e.tk = (rs1 != rs2); e.op = 4'd6; end
        3'd4: begin e.tk = ($signed(rs1) <  $signed(rs2)); e.op = 4'd8; end
        3'd5: begin e.tk = ($signed(rs1) >= $signed(rs2)); e.op = 4'd8; end
        3'd6: begin e.tk = (rs1 <  rs2); e.op = 4'd7; end
        3'd7: begin e.tk = (rs1 >= rs2); e.op = 4'd7; end
        default: e.ill = 1'b1;
      endcase
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) begin
      e.res = 32'h0;
      e.tk  = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a result handshake is about to complete
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid && out_ready) begin
      if (scb.size() == 0) begin
        chk("mon_unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = scb.pop_front();
        chk("mon_result",  result,              mon_e.res);
        chk("mon_taken",   {31'b0, branch_taken}, {31'b0, mon_e.tk});
        chk("mon_illegal", {31'b0, illegal},      {31'b0, mon_e.ill});
      end
    end
  end

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] im, input logic [31:0] pcv, input int hold);
    exp_t e;
    int n;
    logic [31:0] r0;
    logic t0, i0;
    e = model(opc, f3, f7, rs1, rs2, im, pcv);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; opcode = opc; funct3 = f3; funct7b5 = f7;
    rs1_val = rs1; rs2_val = rs2; imm = im; pc = pcv;
    scb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    if (e.ill) begin
      chk("illegal_fast_valid", {31'b0, out_valid}, 32'd1);
      chk("illegal_no_aluop",   {28'b0, alu_op},    32'd0);
    end else begin
      chk("issue_alu_op",   {28'b0, alu_op}, {28'b0, e.op});
      chk("issue_alu_a",    alu_a, e.a);
      chk("issue_alu_b",    alu_b, e.b);
      chk("issue_no_valid", {31'b0, out_valid}, 32'd0);
      chk("issue_in_ready", {31'b0, in_ready},  32'd0);
      @(negedge clk);
      chk("latency_valid",  {31'b0, out_valid}, 32'd1);
      chk("done_alu_op",    {28'b0, alu_op},    32'd0);
    end
    r0 = result; t0 = branch_taken; i0 = illegal;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid",    {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready},  32'd0);
      chk("hold_result",   result, r0);
      chk("hold_flags",    {30'b0, branch_taken, illegal}, {30'b0, t0, i0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid",    {31'b0, out_valid}, 32'd0);
    chk("release_in_ready", {31'b0, in_ready},  32'd1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, 40);
      2:       return ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return 32'h0 - $urandom_range(0, 40);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] bad_opc [4];
    logic [6:0] good_opc [5];
    logic [6:0] o;
    logic [2:0] f;
    logic       f7;
    logic [31:0] r1, r2;
    bad_opc  = '{7'h7F, 7'h03, 7'h23, 7'h6F};
    good_opc = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1100011};

    // in_valid during reset must be ignored
    reset = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
    rs1_val = 32'd1; rs2_val = 32'd2; imm = 32'd0; pc = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result",    result, 32'd0);
    chk("reset_flags",     {30'b0, branch_taken, illegal}, 32'd0);
    chk("reset_alu",       {28'b0, alu_op} | alu_a | alu_b, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("reset_in_valid_ignored", {31'b0, out_valid | ~in_ready}, 32'd0);

    run_instr(7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 0);              // ADD
    run_instr(7'b0110011, 3'd0, 1'b1, 32'd0, 32'd1, 32'd0, 32'd0, 1);              // SUB
    run_instr(7'b0110011, 3'd5, 1'b1, 32'h8000_0000, 32'd33, 32'd0, 32'd0, 0);     // SRA
    run_instr(7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0);      // BLT
    run_instr(7'b1100011, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0);      // BLTU
    run_instr(7'b1100011, 3'd0, 1'b0, 32'd4, 32'd4, 32'd0, 32'd0, 0);              // BEQ
    run_instr(7'b1100011, 3'd1, 1'b0, 32'd4, 32'd4, 32'd0, 32'd0, 0);              // BNE
    run_instr(7'b1100011, 3'd7, 1'b0, 32'd9, 32'd3, 32'd0, 32'd0, 0);              // BGEU
    run_instr(7'b0110011, 3'd6, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 32'd0, 5); // OR, held
    run_instr(7'h7F,      3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 0);              // illegal opcode
    run_instr(7'b0110011, 3'd1, 1'b1, 32'd1, 32'd2, 32'd0, 32'd0, 0);              // OP f3=001 alt
    run_instr(7'b0010011, 3'd1, 1'b1, 32'd1, 32'd0, 32'd3, 32'd0, 0);              // SLLI alt
    run_instr(7'b1100011, 3'd2, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 0);              // BRANCH f3=010
    run_instr(7'b0110111, 3'd0, 1'b0, 32'd9, 32'd9, 32'h1234_5000, 32'd0, 0);      // LUI
    run_instr(7'b0010111, 3'd0, 1'b0, 32'd9, 32'd9, 32'h0000_1000, 32'h400, 0);    // AUIPC
    run_instr(7'b0010011, 3'd0, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFE, 32'd0, 0);     // ADDI ignores alt

    // Reset during ISSUE drops the instruction
    in_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
    rs1_val = 32'd10; rs2_val = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid_issue_op", {28'b0, alu_op}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_valid",    {31'b0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'b0, in_ready},  32'd1);
    chk("rst_mid_alu_op",   {28'b0, alu_op},    32'd0);
    @(negedge clk);
    chk("rst_mid_no_valid", {31'b0, out_valid}, 32'd0);
    run_instr(7'b0010011, 3'd0, 1'b0, 32'd3, 32'd0, 32'hFFFF_FFFD, 32'd0, 0);      // ADDI 3,-3

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) o = bad_opc[$urandom_range(0, 3)];
      else o = good_opc[$urandom_range(0, 4)];
      f  = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      r1 = rnd_val();
      r2 = ($urandom_range(0, 3) == 0) ? r1 : rnd_val();
      run_instr(o, f, f7, r1, r2, rnd_val(), $urandom, $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", scb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
